// File: rtl/dfxsecure_policy_driver_pkg.sv
// Shared types and constants for the DFx secure policy driver.
// Optional policy lock after early-boot exit: DFXSECURE_POLICY_DRIVER_LOCK_EN.
package dfxsecure_policy_driver_pkg;

  localparam int DEFAULT_POLICY_WIDTH = 4;

  // Only policy accepted once early-boot exit has been signalled (lock build).
  localparam logic [DEFAULT_POLICY_WIDTH-1:0] LOCKED_POLICY = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_SETTLE = 2'd3
  } drv_state_e;

  typedef struct packed {
    logic [DEFAULT_POLICY_WIDTH-1:0] policy;
    logic                            earlyboot_exit;
  } policy_req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dfxsecure_policy_driver_if.sv
// Request and plugin-facing signals of the DFx secure policy driver.
// The slave modport is the driver; master is the requester / plugin observer.
interface dfxsecure_policy_driver_if
  import dfxsecure_policy_driver_pkg::*;
#(
  parameter int POLICY_WIDTH = DEFAULT_POLICY_WIDTH
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic [POLICY_WIDTH-1:0] req_policy;
  logic                    req_earlyboot_exit;
  logic [POLICY_WIDTH-1:0] fdfx_secure_policy;
  logic                    fdfx_policy_update;
  logic                    fdfx_earlyboot_exit;
  logic                    busy;
  logic                    resp_err;

  modport slave (
    input  req_valid, req_policy, req_earlyboot_exit,
    output req_ready, fdfx_secure_policy, fdfx_policy_update,
           fdfx_earlyboot_exit, busy, resp_err
  );

  modport master (
    output req_valid, req_policy, req_earlyboot_exit,
    input  req_ready, fdfx_secure_policy, fdfx_policy_update,
           fdfx_earlyboot_exit, busy, resp_err
  );

endinterface

// File: rtl/dfxsecure_seq_timer.sv
// Loadable down-counter timing each phase of the policy update sequence.
// done is high while the count sits at zero.
module dfxsecure_seq_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/dfxsecure_policy_driver.sv
// Sequences policy writes onto the DFx secure policy bus: setup, update strobe, settle.
// Define DFXSECURE_POLICY_DRIVER_LOCK_EN to reject non-locked policies after early-boot exit.
module dfxsecure_policy_driver
  import dfxsecure_policy_driver_pkg::*;
#(
  parameter int                    POLICY_WIDTH  = DEFAULT_POLICY_WIDTH,
  parameter int                    SETUP_CYCLES  = 1,
  parameter int                    UPDATE_CYCLES = 2,
  parameter int                    SETTLE_CYCLES = 4,
  parameter logic [POLICY_WIDTH-1:0] RESET_POLICY = '0
) (
  input logic                        clk,
  input logic                        rst_b,
  dfxsecure_policy_driver_if.slave   bus
);

  localparam int CNT_W = $clog2(max3(SETUP_CYCLES, UPDATE_CYCLES, SETTLE_CYCLES)) + 1;

  drv_state_e              state_q, state_d;
  logic [POLICY_WIDTH-1:0] policy_q;
  logic                    exit_q;
  logic                    resp_err_q;
  logic                    take;
  logic                    reject;
  logic                    lock_hit;
  logic                    tmr_load;
  logic [CNT_W-1:0]        tmr_value;
  logic                    tmr_done;

`ifdef DFXSECURE_POLICY_DRIVER_LOCK_EN
  assign lock_hit = exit_q && (bus.req_policy != POLICY_WIDTH'(LOCKED_POLICY));
`else
  assign lock_hit = 1'b0;
`endif

  dfxsecure_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_b      (rst_b),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  // NOTE: every always_comb output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    reject    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (lock_hit) begin
            reject = 1'b1;
          end else begin
            take      = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(SETUP_CYCLES - 1);
            state_d   = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(UPDATE_CYCLES - 1);
          state_d   = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(SETTLE_CYCLES - 1);
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Policy and exit move only on an accept edge, so they are stable across update and settle.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      policy_q   <= RESET_POLICY;
      exit_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_err_q <= reject;
      if (take) begin
        policy_q <= bus.req_policy;
        if (bus.req_earlyboot_exit) exit_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready           = (state_q == ST_IDLE) && rst_b;
  assign bus.busy                = (state_q != ST_IDLE);
  assign bus.fdfx_policy_update  = (state_q == ST_UPDATE);
  assign bus.fdfx_secure_policy  = policy_q;
  assign bus.fdfx_earlyboot_exit = exit_q;
  assign bus.resp_err            = resp_err_q;

endmodule
